// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM states,
// digit width and a helper that sizes the digit count for a binary width.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int BCD_DIGIT_W = 4;

  // Number of decimal digits needed to hold 2**bin_w - 1.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_val;
    int              n;
    max_val = (64'd1 << bin_w) - 64'd1;
    n       = 1;
    for (int i = 0; i < 20; i++) begin
      if (max_val >= 64'd10) begin
        max_val = max_val / 64'd10;
        n       = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one operand bit per clock.
// Optional macro BCD_SATURATE_EN: flag overflow and clamp the result to all nines.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   op_q, op_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;
  logic               accept;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (work_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

`ifdef BCD_SATURATE_EN
  // When the digit count covers the full binary range nothing can ever spill out.
  localparam bit CAN_TRUNC = (DIGITS < min_digits(BIN_W));
  logic sticky_q, sticky_d;
  logic ovf_q, ovf_d;
`else
  logic unused_top_bit;
  assign unused_top_bit = adj[BCD_W-1];
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    accept  = start && (state_q != SHIFT);
`ifdef BCD_SATURATE_EN
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      SHIFT: begin
        // The adjusted top bit falls off the end: the result wraps modulo 10**DIGITS.
        work_d = {adj[BCD_W-2:0], op_q[BIN_W-1]};
        op_d   = {op_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
`ifdef BCD_SATURATE_EN
        sticky_d = sticky_q | (CAN_TRUNC & adj[BCD_W-1]);
`endif
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        bcd_d   = work_q;
        state_d = IDLE;
`ifdef BCD_SATURATE_EN
        ovf_d = sticky_q;
        if (sticky_q) begin
          bcd_d = {DIGITS{4'h9}};
        end
`endif
      end
      default: ;
    endcase

    if (accept) begin
      op_d    = bin;
      work_d  = '0;
      cnt_d   = CNT_W'(BIN_W);
      state_d = SHIFT;
`ifdef BCD_SATURATE_EN
      sticky_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
`ifdef BCD_SATURATE_EN
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
`ifdef BCD_SATURATE_EN
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BCD_SATURATE_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
